sfx_tone_sequencer: RTL and testbench
=====================================

Name: sfx_tone_sequencer

Overview:
Arbitrates sound-effect requests from the game logic (wall hit, block hit, laser fire, target reward) and drives the square-wave tone oscillator.
- Latches one-cycle event pulses and grants one event at a time by fixed priority.
- For the granted event, outputs that event's half-period for a fixed number of milliseconds, then enforces a silent gap.
- Sits between the game FSM and the oscillator/audio codec path.

Parameters:
NUM_EVENTS, 4, number of request lines; index 0 is highest priority.
TICK_DIV, 50000, CLOCK_50 cycles per 1 ms tick.
GAP_MS, 5, silent gap in ms after every tone.
DUR_W, 8, width of the per-event duration field in ms (max 255).

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high
req  input  NUM_EVENTS  one-cycle event pulses; several may be high in the same cycle
half_period  output  20  oscillator half-wavelength in CLOCK_50 cycles; 0 while silent
tone_on  output  1  high while a tone is playing; the oscillator output is muted when low
osc_restart  output  1  one-cycle pulse on the first PLAY cycle; the oscillator clears its count and phase
busy  output  1  high in PLAY or GAP
active_id  output  2  index of the event being played; holds the last value otherwise
pending  output  NUM_EVENTS  latched, not-yet-served requests (debug)

Behaviour:
- Reset values:
  - state=IDLE; pending=0; half_period=0; tone_on=0; osc_restart=0; busy=0; active_id=0.
  - ms prescaler and ms counter cleared.
- Request latching:
  - Every cycle: pending <= (pending | req) & ~clear_mask.
  - clear_mask is the one-hot bit of the event granted in that cycle.
  - A req arriving in the same cycle it is granted stays cleared.
  - A repeat req for an event already pending is absorbed. There is no counting.
- ms tick:
  - Free-running prescaler, 0..TICK_DIV-1.
  - Reset to 0 on every state entry, so durations are exact: N ms = N*TICK_DIV cycles ±0.
- IDLE:
  - If pending != 0, grant the lowest set index.
  - Load half_period and duration from the package table.
  - Pulse osc_restart and go to PLAY on the next cycle.
  - tone_on and busy rise in the cycle after the grant.
- PLAY:
  - tone_on=1 and busy=1.
  - Count ms ticks; when the count equals the event duration, go to GAP.
  - half_period is forced to 0 and tone_on=0 from the first GAP cycle.
- GAP:
  - tone_on=0 and busy=1 for GAP_MS ms.
  - Then go to IDLE; a new grant can occur in the IDLE cycle.
- Requests received during PLAY or GAP are latched and served in priority order afterwards.
- Duration 0 in the table: the event is treated as 1 ms.
- A mid-operation reset returns to IDLE silent in the next cycle and drops all pending requests.
- Default tone table:
  - id0 wall: 56_818 (440 Hz), 100 ms.
  - id1 block: 31_250 (800 Hz), 60 ms.
  - id2 fire: 25_000 (1 kHz), 30 ms.
  - id3 reward: 20_833 (1.2 kHz), 150 ms.

Optional Feature:
SFX_PREEMPT_EN:
- When defined, a pending request with a strictly lower index than active_id, seen during PLAY, aborts the current tone.
  - The grant happens that same cycle; the new half_period is loaded and osc_restart is pulsed.
  - PLAY restarts with the new duration and no gap.
  - The aborted event is not replayed.
- A request of equal or lower priority, or any request seen during GAP, never preempts.
- When not defined, a tone always plays to completion.

Decomposition:
- Package sfx_pkg holds:
  - the event-id constants;
  - the state enum (IDLE, PLAY, GAP);
  - the half-period and duration table functions indexed by id;
  - the TICK_DIV default.
- One natural sub-module, sfx_ms_timer: prescaler plus ms counter, with restart input, ms_tick output and a done compare against a load value.
- Priority encoder and FSM stay in the top module.

Test Plan:
- After reset, pulse req=0010 → osc_restart in cycle+1, half_period=31_250, tone_on high for exactly 60*50000 cycles, then 5 ms silent, busy falls.
- Simultaneous req=1001 → id0 plays first (56_818, 100 ms), gap, then id3 (20_833, 150 ms); pending goes 1001→1000→0000.
- During an id2 tone, pulse req[2] three times → after the tone and gap, id2 plays exactly once more.
- Assert reset 1000 cycles into an id3 tone → next cycle: tone_on=0, half_period=0, pending=0, IDLE; a later req=0001 works normally.
- With SFX_PREEMPT_EN, req[3] then req[0] 10 ms later → 440 Hz starts in the same cycle req[0] is latched-visible, osc_restart pulses, tone lasts 100 ms, no id3 replay. Without the macro, id3 completes its 150 ms, then gap, then id0.
- Grant-cycle race: req[1] pulses in the exact IDLE grant cycle of id1 → id1 plays once, pending[1]=0 afterwards.

Source files
------------

// File: rtl/sfx_pkg.sv
// sfx_pkg: shared constants, state encoding and the default tone table
// for the sound-effect tone sequencer.
package sfx_pkg;

  localparam int NUM_EVENTS_DEF = 4;
  localparam int TICK_DIV_DEF   = 50_000;  // CLOCK_50 cycles per 1 ms
  localparam int GAP_MS_DEF     = 5;
  localparam int DUR_W_DEF      = 8;
  localparam int HP_W           = 20;
  localparam int ID_W           = 2;

  localparam logic [ID_W-1:0] ID_WALL   = 2'd0;
  localparam logic [ID_W-1:0] ID_BLOCK  = 2'd1;
  localparam logic [ID_W-1:0] ID_FIRE   = 2'd2;
  localparam logic [ID_W-1:0] ID_REWARD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Oscillator half-wavelength in CLOCK_50 cycles for each event.
  function automatic logic [HP_W-1:0] tone_half_period(input logic [ID_W-1:0] id);
    case (id)
      ID_WALL:   return 20'd56_818;  // 440 Hz
      ID_BLOCK:  return 20'd31_250;  // 800 Hz
      ID_FIRE:   return 20'd25_000;  // 1 kHz
      ID_REWARD: return 20'd20_833;  // 1.2 kHz
      default:   return '0;
    endcase
  endfunction

  // Tone length in ms for each event; 0 is played as 1 ms by the sequencer.
  function automatic logic [7:0] tone_duration_ms(input logic [ID_W-1:0] id);
    case (id)
      ID_WALL:   return 8'd100;
      ID_BLOCK:  return 8'd60;
      ID_FIRE:   return 8'd30;
      ID_REWARD: return 8'd150;
      default:   return 8'd1;
    endcase
  endfunction

endpackage

// File: rtl/sfx_tone_sequencer_ms_timer.sv
// sfx_ms_timer: ms prescaler plus ms counter. restart_i zeroes both so the
// next interval starts on an exact ms boundary. done_o flags that the ms in
// progress is the last one of a load_i-ms interval; the interval ends on the
// ms_tick_o that coincides with done_o.
module sfx_ms_timer
  import sfx_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CNT_W    = DUR_W_DEF
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             ms_tick_o,
  output logic             done_o
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRESC_W-1:0] presc_q;
  logic [CNT_W-1:0]   cnt_q;

  assign ms_tick_o = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign done_o    = ((cnt_q + CNT_W'(1)) == load_i);

  // Prescaler wraps every TICK_DIV cycles and advances the ms counter.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset || restart_i) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else if (ms_tick_o) begin
      presc_q <= '0;
      cnt_q   <= cnt_q + CNT_W'(1);
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/sfx_tone_sequencer.sv
// sfx_tone_sequencer: latches sound-effect request pulses, grants them one
// at a time by fixed priority (index 0 highest) and drives the square-wave
// oscillator with the granted tone, followed by a silent gap.
// Optional build macro SFX_PREEMPT_EN: a higher-priority pending request
// aborts a tone in progress (never a gap) and starts immediately.
module sfx_tone_sequencer
  import sfx_pkg::*;
#(
  parameter int NUM_EVENTS = NUM_EVENTS_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int GAP_MS     = GAP_MS_DEF,
  parameter int DUR_W      = DUR_W_DEF
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] req,
  output logic [HP_W-1:0]       half_period,
  output logic                  tone_on,
  output logic                  osc_restart,
  output logic                  busy,
  output logic [ID_W-1:0]       active_id,
  output logic [NUM_EVENTS-1:0] pending
);

  state_t                state_q, state_d;
  logic [NUM_EVENTS-1:0] pending_q, pending_d;
  logic [HP_W-1:0]       hp_q, hp_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DUR_W-1:0]      dur_q, dur_d;
  logic                  restart_q, restart_d;

  logic [NUM_EVENTS-1:0] clear_mask;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_vld;
  logic                  preempt;
  logic                  do_grant;
  logic [DUR_W-1:0]      dur_raw;
  logic                  tmr_restart, tmr_tick, tmr_last;
  logic [DUR_W-1:0]      tmr_load;

  // Priority encoder: lowest set pending index wins.
  always_comb begin
    grant_id  = '0;
    grant_vld = 1'b0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_id  = ID_W'(i);
        grant_vld = 1'b1;
      end
    end
  end

`ifdef SFX_PREEMPT_EN
  assign preempt = grant_vld && (grant_id < id_q);
`else
  assign preempt = 1'b0;
`endif

  assign dur_raw  = DUR_W'(tone_duration_ms(grant_id));
  assign tmr_load = (state_q == GAP) ? DUR_W'(GAP_MS) : dur_q;

  sfx_ms_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (DUR_W)
  ) u_ms_timer (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .restart_i (tmr_restart),
    .load_i    (tmr_load),
    .ms_tick_o (tmr_tick),
    .done_o    (tmr_last)
  );

  // Next-state, grant and request-latch logic.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    id_d        = id_q;
    dur_d       = dur_q;
    restart_d   = 1'b0;
    clear_mask  = '0;
    tmr_restart = 1'b0;
    do_grant    = 1'b0;

    case (state_q)
      IDLE: do_grant = grant_vld;
      PLAY: begin
        if (preempt) begin
          do_grant = 1'b1;
        end else if (tmr_tick && tmr_last) begin
          state_d     = GAP;
          hp_d        = '0;
          tmr_restart = 1'b1;
        end
      end
      GAP: begin
        if (tmr_tick && tmr_last) begin
          state_d     = IDLE;
          tmr_restart = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d     = PLAY;
      hp_d        = tone_half_period(grant_id);
      id_d        = grant_id;
      dur_d       = (dur_raw == '0) ? DUR_W'(1) : dur_raw;
      restart_d   = 1'b1;
      clear_mask  = NUM_EVENTS'(1) << grant_id;
      tmr_restart = 1'b1;
    end

    pending_d = (pending_q | req) & ~clear_mask;
  end

  // State and output registers; reset drops all pending requests.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      hp_q      <= '0;
      id_q      <= '0;
      dur_q     <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hp_q      <= hp_d;
      id_q      <= id_d;
      dur_q     <= dur_d;
      restart_q <= restart_d;
    end
  end

  assign half_period = hp_q;
  assign tone_on     = (state_q == PLAY);
  assign busy        = (state_q != IDLE);
  assign osc_restart = restart_q;
  assign active_id   = id_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_sfx_tone_sequencer.sv
// Testbench for sfx_tone_sequencer with a shortened ms tick. Expected tones
// are queued when requests are driven; a monitor measures each tone and gap.
module tb_sfx_tone_sequencer;

  localparam int TICK    = 10;
  localparam int GAP_CYC = 5 * TICK;

  typedef struct {
    logic [1:0]  id;
    logic [19:0] hp;
    int          len;
  } tone_t;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic [3:0]  req      = 4'b0000;
  logic [19:0] half_period;
  logic        tone_on, osc_restart, busy;
  logic [1:0]  active_id;
  logic [3:0]  pending;

  tone_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  int          cur_len = 0;
  int          gap_len = 0;
  bit          in_gap  = 1'b0;
  logic [1:0]  cur_id  = '0;
  logic [19:0] cur_hp  = '0;

  sfx_tone_sequencer #(.TICK_DIV(TICK)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .req         (req),
    .half_period (half_period),
    .tone_on     (tone_on),
    .osc_restart (osc_restart),
    .busy        (busy),
    .active_id   (active_id),
    .pending     (pending)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic tone_t ref_tone(input int id);
    tone_t t;
    t.id = 2'(id);
    case (id)
      0:       begin t.hp = 20'd56818; t.len = 100 * TICK; end
      1:       begin t.hp = 20'd31250; t.len = 60 * TICK;  end
      2:       begin t.hp = 20'd25000; t.len = 30 * TICK;  end
      default: begin t.hp = 20'd20833; t.len = 150 * TICK; end
    endcase
    return t;
  endfunction

  task automatic finish_tone();
    tone_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL tone_unexpected: got id=%0d hp=%0d len=%0d, required no tone",
               cur_id, cur_hp, cur_len);
    end else begin
      e = sb.pop_front();
      if (cur_id !== e.id || cur_hp !== e.hp || cur_len != e.len) begin
        n_bad++;
        $display("FAIL tone: got id=%0d hp=%0d len=%0d, required id=%0d hp=%0d len=%0d",
                 cur_id, cur_hp, cur_len, e.id, e.hp, e.len);
      end
    end
  endtask

  task automatic run_monitor();
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        cur_len = 0;
        gap_len = 0;
        in_gap  = 1'b0;
      end else if (osc_restart === 1'b1) begin
        if (cur_len > 0) finish_tone();
        cur_id  = active_id;
        cur_hp  = half_period;
        cur_len = 1;
        in_gap  = 1'b0;
      end else if (cur_len > 0 && tone_on === 1'b1) begin
        cur_len++;
      end else if (cur_len > 0) begin
        finish_tone();
        cur_len = 0;
        n_cmp++;
        if (half_period !== 20'd0 || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL gap_entry: got hp=%0d busy=%0b, required hp=0 busy=1", half_period, busy);
        end
        in_gap  = 1'b1;
        gap_len = 1;
      end else if (in_gap) begin
        if (busy === 1'b1) begin
          gap_len++;
        end else begin
          n_cmp++;
          if (gap_len != GAP_CYC) begin
            n_bad++;
            $display("FAIL gap_len: got %0d cycles, required %0d", gap_len, GAP_CYC);
          end
          in_gap = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n  = 0;
    bit ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge CLOCK_50);
      n++;
      ok = (sb.size() == 0) && (busy === 1'b0) && (pending === 4'b0000) &&
           (cur_len == 0) && !in_gap;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d tones outstanding after %0d cycles, required 0",
               tag, sb.size(), budget);
      sb.delete();
    end
    repeat (GAP_CYC) @(negedge CLOCK_50);
  endtask

  task automatic wait_restart(input string tag, input int budget);
    int n  = 0;
    bit ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge CLOCK_50);
      n++;
      ok = (osc_restart === 1'b1);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_restart: got no osc_restart in %0d cycles, required one", tag, budget);
    end
  endtask

  task automatic pulse_req(input logic [3:0] v);
    @(posedge CLOCK_50); #1 req = v;
    @(posedge CLOCK_50); #1 req = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    n_cmp += 6;
    if (half_period !== 20'd0) begin n_bad++; $display("FAIL rst_hp: got %0d, required 0", half_period); end
    if (tone_on !== 1'b0)      begin n_bad++; $display("FAIL rst_tone_on: got %b, required 0", tone_on); end
    if (osc_restart !== 1'b0)  begin n_bad++; $display("FAIL rst_osc_restart: got %b, required 0", osc_restart); end
    if (busy !== 1'b0)         begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (active_id !== 2'd0)    begin n_bad++; $display("FAIL rst_active_id: got %0d, required 0", active_id); end
    if (pending !== 4'b0000)   begin n_bad++; $display("FAIL rst_pending: got %b, required 0000", pending); end
    @(posedge CLOCK_50); #1 reset = 1'b0;
  endtask

  task automatic test_single();
    sb.push_back(ref_tone(1));
    pulse_req(4'b0010);
    @(negedge CLOCK_50);  // grant cycle
    n_cmp += 2;
    if (pending !== 4'b0010) begin n_bad++; $display("FAIL single_grant_pending: got %b, required 0010", pending); end
    if (osc_restart !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_grant_cycle: got restart=%b busy=%b, required 0 0", osc_restart, busy);
    end
    @(negedge CLOCK_50);  // first PLAY cycle
    n_cmp += 2;
    if (osc_restart !== 1'b1 || tone_on !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_play: got restart=%b tone_on=%b busy=%b, required 1 1 1",
                        osc_restart, tone_on, busy);
    end
    if (half_period !== 20'd31250 || pending !== 4'b0000) begin
      n_bad++; $display("FAIL single_hp: got hp=%0d pending=%b, required 31250 0000", half_period, pending);
    end
    wait_idle("single", 3000);
  endtask

  task automatic test_priority();
    sb.push_back(ref_tone(0));
    sb.push_back(ref_tone(3));
    pulse_req(4'b1001);
    @(negedge CLOCK_50);
    n_cmp++;
    if (pending !== 4'b1001) begin n_bad++; $display("FAIL prio_pending0: got %b, required 1001", pending); end
    @(negedge CLOCK_50);
    n_cmp++;
    if (pending !== 4'b1000 || active_id !== 2'd0) begin
      n_bad++; $display("FAIL prio_first: got pending=%b id=%0d, required 1000 0", pending, active_id);
    end
    wait_restart("prio", 3000);
    n_cmp++;
    if (pending !== 4'b0000 || active_id !== 2'd3 || half_period !== 20'd20833) begin
      n_bad++; $display("FAIL prio_second: got pending=%b id=%0d hp=%0d, required 0000 3 20833",
                        pending, active_id, half_period);
    end
    wait_idle("prio", 4000);
  endtask

  task automatic test_repeat();
    sb.push_back(ref_tone(2));
    sb.push_back(ref_tone(2));
    pulse_req(4'b0100);
    wait_restart("repeat", 20);
    for (int k = 0; k < 3; k++) begin
      repeat (40) @(posedge CLOCK_50);
      #1 req = 4'b0100;
      @(posedge CLOCK_50); #1 req = 4'b0000;
    end
    @(negedge CLOCK_50);
    n_cmp++;
    if (pending !== 4'b0100) begin n_bad++; $display("FAIL repeat_pending: got %b, required 0100", pending); end
    wait_idle("repeat", 2000);
  endtask

  task automatic test_reset_mid();
    pulse_req(4'b1000);
    wait_restart("rstmid", 20);
    repeat (500) @(posedge CLOCK_50);
    #1 req = 4'b0010;
    @(posedge CLOCK_50); #1 req = 4'b0000;
    repeat (498) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    n_cmp++;
    if (pending !== 4'b0010 || tone_on !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_before: got pending=%b tone_on=%b, required 0010 1", pending, tone_on);
    end
    @(posedge CLOCK_50); #1 reset = 1'b1;
    @(posedge CLOCK_50); #1 reset = 1'b0;
    @(negedge CLOCK_50);
    n_cmp += 3;
    if (tone_on !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_state: got tone_on=%b busy=%b, required 0 0", tone_on, busy);
    end
    if (half_period !== 20'd0) begin n_bad++; $display("FAIL rstmid_hp: got %0d, required 0", half_period); end
    if (pending !== 4'b0000)   begin n_bad++; $display("FAIL rstmid_pending: got %b, required 0000", pending); end
    sb.push_back(ref_tone(0));
    pulse_req(4'b0001);
    wait_idle("rstmid", 3000);
  endtask

  task automatic test_preempt();
    tone_t t;
    t = ref_tone(3);
`ifdef SFX_PREEMPT_EN
    t.len = 102;  // aborted in PLAY cycle 101; new tone starts in cycle 102
`endif
    sb.push_back(t);
    sb.push_back(ref_tone(0));
    pulse_req(4'b1000);
    wait_restart("preempt", 20);
    repeat (100) @(posedge CLOCK_50);
    #1 req = 4'b0001;
    @(posedge CLOCK_50); #1 req = 4'b0000;
    @(negedge CLOCK_50);
    n_cmp++;
    if (pending !== 4'b0001) begin n_bad++; $display("FAIL preempt_pending: got %b, required 0001", pending); end
    @(negedge CLOCK_50);
    n_cmp++;
`ifdef SFX_PREEMPT_EN
    if (osc_restart !== 1'b1 || half_period !== 20'd56818 || pending !== 4'b0000) begin
      n_bad++; $display("FAIL preempt_switch: got restart=%b hp=%0d pending=%b, required 1 56818 0000",
                        osc_restart, half_period, pending);
    end
`else
    if (osc_restart !== 1'b0 || half_period !== 20'd20833 || pending !== 4'b0001) begin
      n_bad++; $display("FAIL preempt_hold: got restart=%b hp=%0d pending=%b, required 0 20833 0001",
                        osc_restart, half_period, pending);
    end
`endif
    wait_idle("preempt", 6000);
  endtask

  task automatic test_grant_race();
    sb.push_back(ref_tone(1));
    @(posedge CLOCK_50); #1 req = 4'b0010;
    @(posedge CLOCK_50); #1 req = 4'b0010;  // lands in the grant cycle
    @(posedge CLOCK_50); #1 req = 4'b0000;
    @(negedge CLOCK_50);
    n_cmp++;
    if (pending !== 4'b0000 || osc_restart !== 1'b1) begin
      n_bad++; $display("FAIL race: got pending=%b restart=%b, required 0000 1", pending, osc_restart);
    end
    wait_idle("race", 3000);
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_single();
    test_priority();
    test_repeat();
    test_reset_mid();
    test_preempt();
    test_grant_race();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
